output_manager_simd: RTL

- Parametrised DSP-slice output stage, successor to the single-register P output block.
- Takes post-ALU results and adds 0..DEPTH_MAX CEP-gated pipeline stages.
- Supports per-lane SIMD pattern-detect autoreset and an extended serial configuration chain.
- Sits between the ALU/pattern-detector and slice outputs P/PCOUT.

---
 rtl/output_manager_simd.sv | 137 +++++++++++++
 1 files changed

// File: rtl/output_manager_simd.sv
// DSP-slice output stage: 0..DEPTH_MAX CEP-gated P/sideband registers with per-lane pattern autoreset.
// Optional: OUTPUT_MANAGER_AUTORESET_COUNT_EN adds a saturating AUTORESET_CNT of autoreset cycles.
module output_manager_simd #(
  parameter int P_WIDTH   = 48,
  parameter int LANES     = 4,
  parameter int DEPTH_MAX = 2
) (
  input  logic               clk,
  input  logic               RSTP,
  input  logic               CEP,
  input  logic [P_WIDTH-1:0] inter_P,
  input  logic [LANES-1:0]   inter_CARRYOUT,
  input  logic [7:0]         inter_XOROUT,
  input  logic               inter_CARRYCASCOUT,
  input  logic               inter_MULTSIGNOUT,
  input  logic [LANES-1:0]   PATTERNDETECT,
  input  logic [LANES-1:0]   PATTERNBDETECT,
  output logic [P_WIDTH-1:0] P,
  output logic [LANES-1:0]   CARRYOUT,
  output logic [7:0]         XOROUT,
  output logic               CARRYCASCOUT,
  output logic               MULTSIGNOUT,
  output logic               AUTORESET_EVENT,
`ifdef OUTPUT_MANAGER_AUTORESET_COUNT_EN
  output logic [15:0]        AUTORESET_CNT,
`endif
  input  logic               configuration_input,
  input  logic               configuration_enable,
  output logic               configuration_output
);

  localparam int         LW   = P_WIDTH / LANES;
  localparam logic [1:0] DMAX = 2'(DEPTH_MAX);

  typedef struct packed {
    logic [P_WIDTH-1:0] p;
    logic [LANES-1:0]   co;
    logic [7:0]         xo;
    logic               cc;
    logic               ms;
  } stage_t;

  logic       r_simd_en;
  logic [1:0] r_patdet;
  logic       r_prio;
  logic [1:0] r_preg;
  logic       r_event;

  stage_t r_stage [DEPTH_MAX];
  stage_t w_in;
  stage_t w_s1_next;
  stage_t w_out;

  logic [LANES-1:0] w_det;
  logic [LANES-1:0] w_clr;
  logic             w_qual;
  logic [1:0]       w_n;

  // Serial chain order: SIMD_EN -> PATDET[0] -> PATDET[1] -> PRIORITY -> PREG[0] -> PREG[1].
  always_ff @(posedge clk) begin
    if (RSTP) begin
      r_simd_en <= 1'b0;
      r_patdet  <= 2'b00;
      r_prio    <= 1'b0;
      r_preg    <= 2'b00;
    end else if (configuration_enable) begin
      r_simd_en <= configuration_input;
      r_patdet  <= {r_patdet[0], r_simd_en};
      r_prio    <= r_patdet[1];
      r_preg    <= {r_preg[0], r_prio};
    end
  end

  assign configuration_output = r_preg[1];

  assign w_in = '{p: inter_P, co: inter_CARRYOUT, xo: inter_XOROUT,
                  cc: inter_CARRYCASCOUT, ms: inter_MULTSIGNOUT};

  always_comb begin
    w_det = '0;
    case (r_patdet)
      2'b01:   w_det = PATTERNDETECT;
      2'b10:   w_det = PATTERNBDETECT;
      default: w_det = '0;
    endcase
  end

  assign w_qual = r_prio ? CEP : 1'b1;
  assign w_clr  = r_simd_en ? (w_det & {LANES{w_qual}}) : {LANES{w_det[0] & w_qual}};

  // Only the s1 P field is subject to autoreset; sidebands follow CEP alone.
  always_comb begin
    w_s1_next = CEP ? w_in : r_stage[0];
    for (int i = 0; i < LANES; i++) begin
      if (w_clr[i]) w_s1_next.p[i*LW +: LW] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (RSTP) begin
      for (int k = 0; k < DEPTH_MAX; k++) r_stage[k] <= '0;
      r_event <= 1'b0;
    end else begin
      r_stage[0] <= w_s1_next;
      if (CEP) begin
        for (int k = 1; k < DEPTH_MAX; k++) r_stage[k] <= r_stage[k-1];
      end
      r_event <= |w_clr;
    end
  end

`ifdef OUTPUT_MANAGER_AUTORESET_COUNT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk) begin
    if (RSTP) r_cnt <= '0;
    else if ((|w_clr) && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
  end
  assign AUTORESET_CNT = r_cnt;
`endif

  assign w_n = (r_preg > DMAX) ? DMAX : r_preg;

  always_comb begin
    w_out = w_in;
    for (int k = 0; k < DEPTH_MAX; k++) begin
      if (w_n == 2'(k + 1)) w_out = r_stage[k];
    end
  end

  assign P               = w_out.p;
  assign CARRYOUT        = w_out.co;
  assign XOROUT          = w_out.xo;
  assign CARRYCASCOUT    = w_out.cc;
  assign MULTSIGNOUT     = w_out.ms;
  assign AUTORESET_EVENT = r_event;

endmodule
